// File: rtl/sram_bank.sv
// Single-port synchronous SRAM bank with registered read data and no reset on the array.
// Optional macro SRAM_WR_THRU_EN: on write cycles rd also takes wd (write-through).
module sram_bank #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic [ADDR_WIDTH-1:0] ad,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] rd
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  ctrl_x;

`ifndef SYNTHESIS
  assign ctrl_x = $isunknown({cen, wen});
`else
  assign ctrl_x = 1'b0;
`endif

  // Array write sits in the reset-qualified block so no write can land while rst_n is low;
  // the array itself is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
    end else if (ctrl_x) begin
      rd <= 'x;
    end else if (cen) begin
      if (wen) begin
        mem[ad] <= wd;
`ifdef SRAM_WR_THRU_EN
        rd      <= wd;
`endif
      end else begin
        rd <= mem[ad];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!ctrl_x)
        else $error("sram_bank: unknown cen/wen at clock edge, rd corrupted");
    end
  end
`endif

endmodule

// File: tb/tb_sram_bank.sv
// Directed self-checking bench for sram_bank; expectations follow the active SRAM_WR_THRU_EN build.
module tb_sram_bank;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic [AW-1:0] ad;
  logic [DW-1:0] wd;
  logic          wen;
  logic [DW-1:0] rd;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [DW-1:0] PRIME = 64'h0000_0000_0000_0055;
  localparam logic [DW-1:0] PAT   = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] WT    = 64'h0000_0000_0000_A5A5;

  sram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .ad    (ad),
    .wd    (wd),
    .wen   (wen),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cen = c;
    wen = w;
    ad  = a;
    wd  = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    cen   = 1'b1;
    wen   = 1'b1;
    ad    = 10'd5;
    wd    = 64'hDEAD;
    #1;
    repeat (3) tick();
    check("reset_rd", rd, '0);

    // Release, then read ad=5: it must not hold the value offered during reset.
    rst_n = 1'b1;
    access(1'b1, 1'b0, 10'd5, '0);
    check("no_write_in_reset", {63'd0, rd === 64'hDEAD}, '0);

    // Give rd a known prior value.
    access(1'b1, 1'b1, 10'd9, PRIME);
    access(1'b1, 1'b0, 10'd9, '0);
    check("prime_read", rd, PRIME);

    access(1'b1, 1'b1, 10'd3, PAT);
`ifdef SRAM_WR_THRU_EN
    check("write_cycle_rd", rd, PAT);
`else
    check("write_cycle_rd", rd, PRIME);
`endif
    access(1'b1, 1'b0, 10'd3, '0);
    check("read_after_write", rd, PAT);

    for (int i = 0; i < 10; i++) begin
      access(1'b0, i[0], AW'(i * 97), {$urandom, $urandom});
      check($sformatf("idle_hold_%0d", i), rd, PAT);
    end

    // Write enable without chip enable must not touch the array.
    access(1'b0, 1'b1, 10'd3, '0);
    access(1'b1, 1'b0, 10'd9, '0);
    access(1'b1, 1'b0, 10'd3, '0);
    check("ignored_write", rd, PAT);

    access(1'b1, 1'b1, 10'd0, 64'h1);
    access(1'b1, 1'b1, 10'd1023, ONES);
    access(1'b1, 1'b0, 10'd0, '0);
    check("stream_0", rd, 64'h1);
    access(1'b1, 1'b0, 10'd1023, '0);
    check("stream_1023", rd, ONES);
    access(1'b1, 1'b0, 10'd0, '0);
    check("stream_0_again", rd, 64'h1);

    access(1'b1, 1'b1, 10'd7, WT);
`ifdef SRAM_WR_THRU_EN
    check("wt_write_edge", rd, WT);
`else
    check("wt_write_edge", rd, 64'h1);
`endif
    access(1'b1, 1'b0, 10'd7, '0);
    check("wt_readback", rd, WT);

    // Asynchronous reset between edges while streaming reads.
    access(1'b1, 1'b0, 10'd1023, '0);
    check("pre_async_rd", rd, ONES);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rd", rd, '0);
    tick();
    rst_n = 1'b1;
    access(1'b1, 1'b0, 10'd3, '0);
    check("array_kept_over_reset", rd, PAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
